// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one single-port 32x8 RAM between two req/ack clients.
// Define ARB_FIXED_PRIO_EN for fixed priority (port 0 always wins contention; port 1 may starve).
module ram_arbiter #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_q,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t state;
  logic   owner;
  logic   owner_write;
  logic   last_grant;
  logic   sel;

  // Port chosen if a grant happens this cycle; only consumed in IDLE.
  always_comb begin
    sel = 1'b0;
    if (req0 && req1) begin
`ifdef ARB_FIXED_PRIO_EN
      sel = 1'b0;
`else
      sel = ~last_grant;
`endif
    end else if (req1) begin
      sel = 1'b1;
    end else begin
      sel = 1'b0;
    end
  end

  // Access sequencer: grant, one RAM issue cycle, capture, one-cycle ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      owner_write <= 1'b0;
      last_grant  <= 1'b1;
      ram_address <= {AW{1'b0}};
      ram_data    <= {DW{1'b0}};
      ram_wren    <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rdata0      <= {DW{1'b0}};
      rdata1      <= {DW{1'b0}};
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner       <= sel;
            owner_write <= sel ? we1 : we0;
            ram_address <= sel ? addr1 : addr0;
            ram_data    <= sel ? wdata1 : wdata0;
            ram_wren    <= sel ? we1 : we0;
            busy        <= 1'b1;
            state       <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          // The RAM has registered wren at this edge; never let it see a second write.
          ram_wren <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          if (owner) begin
            ack1 <= 1'b1;
            if (!owner_write) begin
              rdata1 <= ram_q;
            end
          end else begin
            ack0 <= 1'b1;
            if (!owner_write) begin
              rdata0 <= ram_q;
            end
          end
          last_grant <= owner;
          state      <= ACK;
        end
        ACK: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack0     <= 1'b0;
          ack1     <= 1'b0;
          ram_wren <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vector table, hand sequences and a randomized run checked
// against a transaction-level model of the arbiter and RAM.
module tb_ram_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [4:0] addr0 = 5'd0, addr1 = 5'd0;
  logic [7:0] wdata0 = 8'd0, wdata1 = 8'd0;
  logic       ack0, ack1, ram_wren, busy;
  logic [7:0] rdata0, rdata1, ram_data, ram_q;
  logic [4:0] ram_address;

  int tests = 0;
  int fails = 0;

  ram_arbiter #(.AW(5), .DW(8)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Behavioural ramlpm: registered address/data/wren, unregistered q.
  logic       mem_init = 1'b1;
  logic [7:0] mem [32];
  logic [4:0] addr_q;

  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 37) + 11);
  endfunction

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
    end else if (ram_wren) begin
      mem[ram_address] <= ram_data;
    end
    addr_q <= ram_address;
  end
  assign ram_q = mem[addr_q];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack0"}, ack0, 0);
    check({tag, "_ack1"}, ack1, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_wren"}, ram_wren, 0);
    check({tag, "_addr"}, ram_address, 0);
    check({tag, "_data"}, ram_data, 0);
    check({tag, "_rdata0"}, rdata0, 0);
    check({tag, "_rdata1"}, rdata1, 0);
  endtask

  task automatic do_reset(input logic init);
    req0 = 1'b0; req1 = 1'b0;
    reset = 1'b1; mem_init = init;
    tick(); tick();
    reset = 1'b0; mem_init = 1'b0;
  endtask

  // One complete access through a port; ack must appear exactly 3 cycles after the grant edge.
  task automatic do_access(input logic p, input logic we, input logic [4:0] a, input logic [7:0] d);
    int  k;
    bit  seen;
    seen = 1'b0;
    k = 0;
    if (p) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    for (int i = 1; i <= 12; i++) begin
      tick();
      if ((p ? ack1 : ack0) === 1'b1) begin seen = 1'b1; k = i; break; end
    end
    check("ack_seen", seen, 1);
    check("ack_latency", k, 3);
    if (p) req1 = 1'b0; else req0 = 1'b0;
    tick();
  endtask

  typedef struct {
    logic       req0;
    logic       we0;
    logic [4:0] addr0;
    logic [7:0] wdata0;
    logic       e_ack0;
    logic       e_busy;
    logic       e_wren;
    logic [4:0] e_addr;
    logic [7:0] e_data;
    logic [7:0] e_rdata0;
  } vec_t;

  vec_t vecs [8];

  // Transaction-level model state for the random run.
  bit         m_req [2];
  bit         m_we  [2];
  logic [4:0] m_addr[2];
  logic [7:0] m_wd  [2];
  logic [7:0] ref_mem [32];
  logic [7:0] exp_rd [2];
  int         since_grant;
  bit         m_owner, m_last, m_own_we;
  logic [4:0] m_own_addr;
  logic [7:0] m_own_rd;
  logic [7:0] prev_rd1;

  task automatic drive_model_inputs();
    req0 = m_req[0]; we0 = m_we[0]; addr0 = m_addr[0]; wdata0 = m_wd[0];
    req1 = m_req[1]; we1 = m_we[1]; addr1 = m_addr[1]; wdata1 = m_wd[1];
  endtask

  task automatic new_req(input int p);
    m_req[p]  = 1'b1;
    m_we[p]   = 1'($urandom_range(1, 0));
    m_addr[p] = 5'($urandom_range(31, 0));
    m_wd[p]   = 8'($urandom_range(255, 0));
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 5'd3, 8'hA5, 1'b0, 1'b1, 1'b1, 5'd3, 8'hA5, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 5'd3, 8'hA5, 1'b0, 1'b1, 1'b0, 5'd3, 8'hA5, 8'h00};
    vecs[2] = '{1'b1, 1'b1, 5'd3, 8'hA5, 1'b1, 1'b1, 1'b0, 5'd3, 8'hA5, 8'h00};
    vecs[3] = '{1'b0, 1'b0, 5'd3, 8'h00, 1'b0, 1'b0, 1'b0, 5'd3, 8'hA5, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 5'd3, 8'h00, 1'b0, 1'b1, 1'b0, 5'd3, 8'h00, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 5'd3, 8'h00, 1'b0, 1'b1, 1'b0, 5'd3, 8'h00, 8'h00};
    vecs[6] = '{1'b1, 1'b0, 5'd3, 8'h00, 1'b1, 1'b1, 1'b0, 5'd3, 8'h00, 8'hA5};
    vecs[7] = '{1'b0, 1'b0, 5'd3, 8'h00, 1'b0, 1'b0, 1'b0, 5'd3, 8'h00, 8'hA5};

    do_reset(1'b1);
    check_reset_outputs("reset");

    // Write A5 to address 3, then read it back.
    for (int i = 0; i < 8; i++) begin
      req0 = vecs[i].req0; we0 = vecs[i].we0; addr0 = vecs[i].addr0; wdata0 = vecs[i].wdata0;
      tick();
      check($sformatf("vec%0d_ack0", i), ack0, vecs[i].e_ack0);
      check($sformatf("vec%0d_ack1", i), ack1, 0);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      check($sformatf("vec%0d_wren", i), ram_wren, vecs[i].e_wren);
      check($sformatf("vec%0d_addr", i), ram_address, vecs[i].e_addr);
      check($sformatf("vec%0d_data", i), ram_data, vecs[i].e_data);
      check($sformatf("vec%0d_rdata0", i), rdata0, vecs[i].e_rdata0);
    end

    // Continuous contention between two readers.
    do_reset(1'b1);
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd2;
    for (int c = 1; c <= 16; c++) begin
      tick();
`ifdef ARB_FIXED_PRIO_EN
      check($sformatf("cont%0d_ack0", c), ack0, (c % 4) == 3);
      check($sformatf("cont%0d_ack1", c), ack1, 0);
`else
      check($sformatf("cont%0d_ack0", c), ack0, (c == 3) || (c == 11));
      check($sformatf("cont%0d_ack1", c), ack1, (c == 7) || (c == 15));
`endif
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    check("cont_rdata0", rdata0, init_val(1));
`ifdef ARB_FIXED_PRIO_EN
    prev_rd1 = 8'h00;
`else
    prev_rd1 = init_val(2);
`endif
    check("cont_rdata1", rdata1, prev_rd1);

    // Port 1 writes address 31, port 0 reads it.
    do_access(1'b1, 1'b1, 5'd31, 8'h3C);
    do_access(1'b0, 1'b0, 5'd31, 8'h00);
    check("wrap_rdata0", rdata0, 8'h3C);
    check("wrap_rdata1_held", rdata1, prev_rd1);

    // Reset during WAIT of a port 1 read abandons it.
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd5;
    tick(); tick();
    reset = 1'b1; req1 = 1'b0;
    tick();
    check_reset_outputs("midreset");
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("midreset_noack1_%0d", c), ack1, 0);
    end
    do_access(1'b0, 1'b0, 5'd31, 8'h00);
    check("post_reset_rdata0", rdata0, 8'h3C);

    // Request inputs moving during ISSUE/WAIT must not reach the RAM.
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd10; wdata0 = 8'h5A;
    tick();
    check("hold_addr_e0", ram_address, 5'd10);
    check("hold_data_e0", ram_data, 8'h5A);
    check("hold_wren_e0", ram_wren, 1);
    addr0 = 5'd20; wdata0 = 8'hFF;
    tick();
    check("hold_addr_e1", ram_address, 5'd10);
    check("hold_data_e1", ram_data, 8'h5A);
    check("hold_wren_e1", ram_wren, 0);
    addr0 = 5'd7; wdata0 = 8'h00;
    tick();
    check("hold_ack0", ack0, 1);
    check("hold_addr_e2", ram_address, 5'd10);
    req0 = 1'b0;
    tick();
    do_access(1'b0, 1'b0, 5'd10, 8'h00);
    check("hold_rd10", rdata0, 8'h5A);
    do_access(1'b0, 1'b0, 5'd20, 8'h00);
    check("hold_rd20", rdata0, init_val(20));

    // Randomized run against the transaction-level model.
    do_reset(1'b1);
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
    for (int p = 0; p < 2; p++) begin
      m_req[p] = 1'b0; m_we[p] = 1'b0; m_addr[p] = 5'd0; m_wd[p] = 8'd0; exp_rd[p] = 8'd0;
    end
    since_grant = -1;
    m_last = 1'b1;
    m_owner = 1'b0;
    m_own_we = 1'b0;
    m_own_addr = 5'd0;
    m_own_rd = 8'd0;
    drive_model_inputs();
    for (int c = 0; c < 800; c++) begin
      tick();
      if (since_grant < 0) begin
        if (m_req[0] || m_req[1]) begin
`ifdef ARB_FIXED_PRIO_EN
          m_owner = m_req[0] ? 1'b0 : 1'b1;
`else
          m_owner = (m_req[0] && m_req[1]) ? !m_last : m_req[1];
`endif
          m_own_we   = m_we[m_owner];
          m_own_addr = m_addr[m_owner];
          if (m_own_we) ref_mem[m_own_addr] = m_wd[m_owner];
          else m_own_rd = ref_mem[m_own_addr];
          since_grant = 0;
        end
      end else begin
        since_grant++;
        if (since_grant == 2) begin
          if (!m_own_we) exp_rd[m_owner] = m_own_rd;
          m_last = m_owner;
        end
        if (since_grant == 3) since_grant = -1;
      end
      check("rnd_ack0", ack0, (since_grant == 2) && !m_owner);
      check("rnd_ack1", ack1, (since_grant == 2) && m_owner);
      check("rnd_busy", busy, since_grant >= 0);
      check("rnd_wren", ram_wren, (since_grant == 0) && m_own_we);
      check("rnd_rdata0", rdata0, exp_rd[0]);
      check("rnd_rdata1", rdata1, exp_rd[1]);
      if (since_grant >= 0) check("rnd_addr", ram_address, m_own_addr);
      for (int p = 0; p < 2; p++) begin
        if (m_req[p] && (since_grant == 2) && (int'(m_owner) == p)) begin
          if ($urandom_range(1, 0) == 0) m_req[p] = 1'b0;
          else new_req(p);
        end else if (!m_req[p] && ($urandom_range(9, 0) < 4)) begin
          new_req(p);
        end
      end
      drive_model_inputs();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Round-robin arbiter that shares the single-port 32x8 RAM (ramlpm: address[4:0], data[7:0], wren, q[7:0], registered address/data/wren, unregistered q) between two requesters.
- Sits between the RAM instance and two clients, e.g. a switch-driven front panel and an autonomous sequencer.
- Each access is one read or one write, using a level req / pulsed ack handshake.

Parameters:
- AW, 5, RAM address width (32 words)
- DW, 8, RAM data width

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req0  in  1  port 0 access request, level; held until ack0
- we0  in  1  port 0 write (1) / read (0); stable while req0
- addr0  in  AW  port 0 word address; stable while req0
- wdata0  in  DW  port 0 write data; stable while req0
- ack0  out  1  port 0 completion pulse, 1 cycle
- rdata0  out  DW  port 0 read data; valid while ack0 after a read
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1
- ram_address  out  AW  to RAM address
- ram_data  out  DW  to RAM data
- ram_wren  out  1  to RAM wren
- ram_q  in  DW  from RAM q
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: ram_address=0, ram_data=0, ram_wren=0, ack0=ack1=0, rdata0=rdata1=0, busy=0, state=IDLE, last_grant=1 (port 0 wins first contention).
- Reset asserted in any state returns all of the above at the next edge. An in-flight access is abandoned with no ack. A write whose ram_wren was already sampled by the RAM is not undone.
- FSM, Moore outputs, all outputs registered:
  - IDLE: no req -> stay. Any req -> select owner (below). Register ram_address, ram_data, ram_wren from the owner's addr/wdata/we. Set owner register. Go to ISSUE.
  - ISSUE: RAM samples address/data/wren at the end of this cycle. Clear ram_wren to 0 at this edge. Go to WAIT.
  - WAIT: ram_q is valid. If the owner's access was a read, register rdataN<=ram_q. Set ackN<=1. Set last_grant<=owner. Go to ACK.
  - ACK: ackN=1 for exactly this cycle. Clear ackN. Go to IDLE.
- ram_wren is high for exactly one cycle (ISSUE) per write and is never high for reads.
- ram_address and ram_data hold their last values when not in use.
- Latency: req sampled at edge E0 -> ack visible in the cycle after E2. Fixed 3 cycles from grant.
- Throughput: one access per 4 cycles. Back-to-back requests from one port are served at that rate.
- Selection in IDLE:
  - only req0 -> port 0; only req1 -> port 1
  - both -> port != last_grant (round-robin)
- Requests are sampled only in IDLE. Changes to req/addr/we/wdata during ISSUE/WAIT/ACK are ignored. A requester may drop req or present a new request on the edge that ends ACK.
- The non-owner's req stays pending. It is guaranteed a grant in the next arbitration, so no starvation.
- rdataN is not modified by writes or by the other port's accesses. It holds its value between reads.
- ack0 and ack1 are never both high.
- Address wrap: addresses are used verbatim. No auto-increment; 31 and 0 are ordinary addresses.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN
- Defined: fixed priority. Port 0 wins whenever req0 is high in IDLE. last_grant is still updated but ignored. Port 1 can starve.
- Undefined (default): round-robin as specified above.

Test Plan:
- Reset, then req0=1, we0=1, addr0=5'h03, wdata0=8'hA5 -> ram_wren high exactly one cycle with ram_address=3, ram_data=A5. ack0 pulses 1 cycle, 3 cycles after the grant edge. busy high for 3 cycles.
- Then req0=1, we0=0, addr0=3 -> ack0 pulse with rdata0=8'hA5. ram_wren stays 0.
- req0 and req1 both high continuously (reads of addr 1 and addr 2) -> grant order 0,1,0,1. Acks alternate, one ack per 4 cycles. Round-robin only; under ARB_FIXED_PRIO_EN only ack0 ever pulses.
- Port 1 writes 8'h3C to addr 31, then port 0 reads addr 31 -> rdata0=8'h3C. rdata1 stays at its previous value.
- Assert reset during WAIT of a port 1 read -> no ack1 pulse. All outputs take reset values at the next edge. A new req0 read after reset completes normally.
- Toggle addr0/wdata0 during ISSUE and WAIT -> RAM sees only the values sampled in IDLE. Data written matches the originally presented wdata0.
